// File: rtl/stack_pkg.sv
// Shared definitions for the stack processor: opcodes, sequencer state
// encoding, default widths and the depth-legality helper.
package stack_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 32;

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NOT  = 3'b101;
   localparam logic [2:0] OP_DUP  = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_POP1  = 4'd1,
      S_POP2  = 4'd2,
      S_CAPA  = 4'd3,
      S_CAPB  = 4'd4,
      S_TOS   = 4'd5,
      S_PUSHI = 4'd6,
      S_PUSHR = 4'd7,
      S_DONE  = 4'd8
   } state_e;

   // True when the op can run at the given occupancy without under/overflow.
   function automatic logic op_ok(input logic [2:0] op, input logic [5:0] depth,
                                  input logic [5:0] max_depth);
      logic ok;
      ok = 1'b1;
      case (op)
         OP_PUSH:                ok = (depth < max_depth);
         OP_POP, OP_NOT:         ok = (depth >= 6'd1);
         OP_DUP:                 ok = (depth >= 6'd1) && (depth < max_depth);
         OP_ADD, OP_SUB, OP_AND: ok = (depth >= 6'd2);
         default:                ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Decoder-to-sequencer op handshake.
// Handshake: an op transfers on the rising edge where start && ready; the
// decoder holds opcode/imm stable while start is high. ready drops for the
// whole op and the sequencer answers with a single-cycle done pulse carrying
// err/result; start is ignored while ready is low.
interface stack_op_sequencer_if #(parameter int DATA_W = 8);
   logic              start;
   logic [2:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic              ready;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result;

   modport master (output start, opcode, imm, input ready, done, err, result);
   modport slave  (input start, opcode, imm, output ready, done, err, result);
endinterface

// File: rtl/stack_alu.sv
// Combinational ALU shared by the sequencer and the processor datapath.
// b is the top of stack (popped first), a the entry below it.
module stack_alu
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   // Modulo arithmetic, no flags; non-ALU ops pass b through (used by DUP).
   always_comb begin
      y = b;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_NOT:  y = ~b;
         default: y = b;
      endcase
   end

endmodule

// File: rtl/stack_op_sequencer.sv
// Control stage in front of the stack: runs one op at a time, drives the
// stack strobes, captures the registered stack output and tracks depth.
module stack_op_sequencer
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   stack_op_sequencer_if.slave bus,
   output logic [5:0]        depth,
   output logic              stk_push,
   output logic              stk_pop,
   output logic              stk_tos,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout,
   output state_e            state_dbg
);

   localparam logic [5:0] MAX_DEPTH = 6'(DEPTH);

   state_e            state_q;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] b_q;
   logic              hold_q;   // NOP/reject: wait one cycle in DONE before pulsing
   logic              rej_q;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_y;

   assign state_dbg = state_q;

   // In CAPB the top value is arriving on stk_dout right now; elsewhere it is held in b_q.
   always_comb begin
      alu_b = b_q;
      if (state_q == S_CAPB) alu_b = stk_dout;
   end

   // a comes straight off the stack output in CAPA, the cycle it is valid.
   stack_alu #(.DATA_W(DATA_W)) u_alu (
      .op (op_q),
      .a  (stk_dout),
      .b  (alu_b),
      .y  (alu_y)
   );

   // Sequencer FSM; strobes and handshake outputs are registered on entry to each state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NOP;
         b_q        <= '0;
         hold_q     <= 1'b0;
         rej_q      <= 1'b0;
         depth      <= '0;
         stk_push   <= 1'b0;
         stk_pop    <= 1'b0;
         stk_tos    <= 1'b0;
         stk_din    <= '0;
         bus.ready  <= 1'b1;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.result <= '0;
      end else begin
         stk_push   <= 1'b0;
         stk_pop    <= 1'b0;
         stk_tos    <= 1'b0;
         stk_din    <= '0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.result <= '0;

         if (stk_push)     depth <= depth + 6'd1;
         else if (stk_pop) depth <= depth - 6'd1;

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  bus.ready <= 1'b0;
                  op_q      <= bus.opcode;
                  if (!op_ok(bus.opcode, depth, MAX_DEPTH)) begin
                     state_q <= S_DONE;
                     hold_q  <= 1'b1;
                     rej_q   <= 1'b1;
                  end else begin
                     case (bus.opcode)
                        OP_PUSH: begin
                           state_q  <= S_PUSHI;
                           stk_push <= 1'b1;
                           stk_din  <= bus.imm;
                        end
                        OP_DUP: begin
                           state_q <= S_TOS;
                           stk_tos <= 1'b1;
                        end
                        OP_NOP: begin
                           state_q <= S_DONE;
                           hold_q  <= 1'b1;
                           rej_q   <= 1'b0;
                        end
                        default: begin
                           state_q <= S_POP1;
                           stk_pop <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_POP1: begin
               if (op_q == OP_POP || op_q == OP_NOT) begin
                  state_q <= S_CAPB;
               end else begin
                  state_q <= S_POP2;
                  stk_pop <= 1'b1;
               end
            end
            S_POP2: begin
               b_q     <= stk_dout;
               state_q <= S_CAPA;
            end
            S_CAPA: begin
               state_q  <= S_PUSHR;
               stk_push <= 1'b1;
               stk_din  <= alu_y;
            end
            S_TOS: begin
               state_q <= S_CAPB;
            end
            S_CAPB: begin
               b_q <= stk_dout;
               if (op_q == OP_POP) begin
                  state_q    <= S_DONE;
                  bus.done   <= 1'b1;
                  bus.result <= stk_dout;
               end else begin
                  state_q  <= S_PUSHR;
                  stk_push <= 1'b1;
                  stk_din  <= alu_y;
               end
            end
            S_PUSHI, S_PUSHR: begin
               state_q    <= S_DONE;
               bus.done   <= 1'b1;
               bus.result <= stk_din;
            end
            S_DONE: begin
               if (hold_q) begin
                  hold_q   <= 1'b0;
                  bus.done <= 1'b1;
                  bus.err  <= rej_q;
               end else begin
                  state_q   <= S_IDLE;
                  bus.ready <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               bus.ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural 32-entry stack, directed op table
// with hand-computed results, overflow fill and reset-in-POP2 sequence.
module tb_stack_op_sequencer;
   import stack_pkg::*;

   typedef struct {
      logic [2:0] op;
      logic [7:0] imm;
      logic       exp_err;
      logic [7:0] exp_res;
      logic [5:0] exp_depth;
      int         exp_lat;
      int         exp_push;
      int         exp_pop;
      int         exp_tos;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] depth;
   logic       stk_push, stk_pop, stk_tos;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;
   state_e     state_dbg;

   int n_vec = 0;
   int n_miss = 0;

   stack_op_sequencer_if #(.DATA_W(8)) bus ();

   stack_op_sequencer #(.DATA_W(8), .DEPTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .depth     (depth),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_tos   (stk_tos),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stack: registered d_out, pointer cleared with the processor restart.
   logic [7:0] mem [0:31];
   int         sp;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_push) begin
         mem[sp[4:0]] <= stk_din;
         sp           <= sp + 1;
      end else if (stk_pop) begin
         stk_dout <= mem[5'(sp - 1)];
         sp       <= sp - 1;
      end else if (stk_tos) begin
         stk_dout <= mem[5'(sp - 1)];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] imm, input logic e,
                               input logic [7:0] res, input logic [5:0] d, input int lat,
                               input int np, input int npop, input int nt);
      vec_t v;
      v.op = op; v.imm = imm; v.exp_err = e; v.exp_res = res; v.exp_depth = d;
      v.exp_lat = lat; v.exp_push = np; v.exp_pop = npop; v.exp_tos = nt;
      return v;
   endfunction

   // driver: issue one op from IDLE and check completion, strobes and return to IDLE
   task automatic run_op(input vec_t v, input string tag);
      int  cyc, np, npop, nt;
      bit  got;
      n_vec++;
      bus.opcode = v.op;
      bus.imm    = v.imm;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1; np = 0; npop = 0; nt = 0; got = 0;
      while (cyc <= 20) begin
         if (stk_push) np++;
         if (stk_pop)  npop++;
         if (stk_tos)  nt++;
         if ((32'(stk_push) + 32'(stk_pop) + 32'(stk_tos)) > 1)
            check({tag, " strobe_excl"}, 32'(stk_push) + 32'(stk_pop) + 32'(stk_tos), 1);
         if (bus.done) begin
            got = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!got) begin
         check({tag, " done_timeout"}, 0, 1);
      end else begin
         check({tag, " latency"}, cyc, v.exp_lat);
         check({tag, " err"}, 32'(bus.err), 32'(v.exp_err));
         check({tag, " result"}, 32'(bus.result), 32'(v.exp_res));
         check({tag, " depth"}, 32'(depth), 32'(v.exp_depth));
         check({tag, " n_push"}, np, v.exp_push);
         check({tag, " n_pop"}, npop, v.exp_pop);
         check({tag, " n_tos"}, nt, v.exp_tos);
      end
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 32'(bus.done), 0);
      check({tag, " ready_after"}, 32'(bus.ready), 1);
   endtask

   vec_t vecs [17];

   initial begin
      bus.start  = 1'b0;
      bus.opcode = OP_NOP;
      bus.imm    = '0;
      rst_n      = 1'b0;

      vecs[0]  = mk(OP_PUSH, 8'h05, 0, 8'h05, 1, 2, 1, 0, 0);
      vecs[1]  = mk(OP_PUSH, 8'h03, 0, 8'h03, 2, 2, 1, 0, 0);
      vecs[2]  = mk(OP_SUB,  8'h00, 0, 8'h02, 1, 5, 1, 2, 0);
      vecs[3]  = mk(OP_POP,  8'h00, 0, 8'h02, 0, 3, 0, 1, 0);
      vecs[4]  = mk(OP_POP,  8'h00, 1, 8'h00, 0, 2, 0, 0, 0);
      vecs[5]  = mk(OP_PUSH, 8'h07, 0, 8'h07, 1, 2, 1, 0, 0);
      vecs[6]  = mk(OP_ADD,  8'h00, 1, 8'h00, 1, 2, 0, 0, 0);
      vecs[7]  = mk(OP_DUP,  8'h00, 0, 8'h07, 2, 4, 1, 0, 1);
      vecs[8]  = mk(OP_PUSH, 8'hF0, 0, 8'hF0, 3, 2, 1, 0, 0);
      vecs[9]  = mk(OP_PUSH, 8'h20, 0, 8'h20, 4, 2, 1, 0, 0);
      vecs[10] = mk(OP_ADD,  8'h00, 0, 8'h10, 3, 5, 1, 2, 0);
      vecs[11] = mk(OP_PUSH, 8'hAA, 0, 8'hAA, 4, 2, 1, 0, 0);
      vecs[12] = mk(OP_PUSH, 8'h0F, 0, 8'h0F, 5, 2, 1, 0, 0);
      vecs[13] = mk(OP_AND,  8'h00, 0, 8'h0A, 4, 5, 1, 2, 0);
      vecs[14] = mk(OP_NOT,  8'h00, 0, 8'hF5, 4, 4, 1, 1, 0);
      vecs[15] = mk(OP_NOP,  8'h00, 0, 8'h00, 4, 2, 0, 0, 0);
      vecs[16] = mk(OP_POP,  8'h00, 0, 8'hF5, 3, 3, 0, 1, 0);

      // reset state
      #12;
      n_vec++;
      check("rst ready", 32'(bus.ready), 1);
      check("rst done", 32'(bus.done), 0);
      check("rst err", 32'(bus.err), 0);
      check("rst result", 32'(bus.result), 0);
      check("rst depth", 32'(depth), 0);
      check("rst strobes", {29'd0, stk_push, stk_pop, stk_tos}, 0);
      check("rst din", 32'(stk_din), 0);
      check("rst state", 32'(state_dbg), 32'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed op table
      for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("v%0d", i));

      // fill to 32 entries (stack currently holds 3)
      for (int i = 0; i < 29; i++)
         run_op(mk(OP_PUSH, 8'(8'h40 + i), 0, 8'(8'h40 + i), 6'(4 + i), 2, 1, 0, 0),
                $sformatf("fill%0d", i));
      run_op(mk(OP_PUSH, 8'h99, 1, 8'h00, 32, 2, 0, 0, 0), "push_full");
      run_op(mk(OP_DUP,  8'h00, 1, 8'h00, 32, 2, 0, 0, 0), "dup_full");
      run_op(mk(OP_POP,  8'h00, 0, 8'h5C, 31, 3, 0, 1, 0), "pop_full");

      // reset asserted while in POP2
      n_vec++;
      bus.opcode = OP_ADD;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("mid C1 state", 32'(state_dbg), 32'(S_POP1));
      @(posedge clk); #1;
      check("mid C2 state", 32'(state_dbg), 32'(S_POP2));
      check("mid C2 pop", 32'(stk_pop), 1);
      rst_n = 1'b0;
      #1;
      check("mid rst strobes", {29'd0, stk_push, stk_pop, stk_tos}, 0);
      check("mid rst state", 32'(state_dbg), 32'(S_IDLE));
      check("mid rst depth", 32'(depth), 0);
      check("mid rst ready", 32'(bus.ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(mk(OP_PUSH, 8'h55, 0, 8'h55, 1, 2, 1, 0, 0), "post_rst_push");
      run_op(mk(OP_POP,  8'h00, 0, 8'h55, 0, 3, 0, 1, 0), "post_rst_pop");

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
